imem_loader: RTL and testbench

Boot-time controller that fills the single-cycle core's 1024×32 instruction memory from a byte stream and holds the core in reset until the program image is fully written. It sits between a byte source (UART receiver or debug port) and the instruction memory's write port. It also drives the core's reset so that fetch never reads a partially loaded image.

---
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: fills the instruction memory from a length-prefixed byte stream and
// holds the core in reset until the whole image has been written.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StDone,
    StErr
  } state_e;

  localparam logic [ADDR_W:0] IdxOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;

  logic                in_session;
  logic                accept;
  logic                last_byte;
  logic                last_word;
  logic                hdr_bad;
  logic [31:0]         shift_next;

  assign in_session = (state_q == StHdr) || (state_q == StData);
  assign accept     = rx_valid && in_session;
  assign last_byte  = accept && (byte_cnt_q == 2'd3);
  // Bytes arrive LSB first, so shifting in from the top leaves byte 0 in [7:0].
  assign shift_next = {rx_data, shift_q[31:8]};
  assign hdr_bad    = (shift_next == 32'd0) || (shift_next > MAX_WORDS);
  assign last_word  = (word_idx_q + IdxOne) == word_count_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = shift_next;
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StHdr;
          byte_cnt_d   = 2'd0;
          shift_d      = 32'd0;
          word_idx_d   = '0;
          word_count_d = '0;
          mem_waddr_d  = '0;
        end
      end
      StHdr: begin
        if (last_byte) begin
          if (hdr_bad) begin
            state_d = StErr;
          end else begin
            word_count_d = shift_next[ADDR_W:0];
            state_d      = StData;
          end
        end
      end
      StData: begin
        if (last_byte) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = word_idx_q[ADDR_W-1:0];
          mem_wdata_d = shift_next;
          word_idx_d  = word_idx_q + IdxOne;
          if (last_word) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Release the core only once DONE has been held across an edge, i.e. after the final write.
  assign cpu_rst_n_d = (state_q == StDone) && (state_d == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 32'd0;
      word_idx_q   <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= 32'd0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
    end
  end

  assign rx_ready   = in_session;
  assign busy       = in_session;
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized images, gaps and start noise; a monitor
// checks every memory write against writes predicted from the stream format.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] word_count;

  imem_loader #(
    .ADDR_W    (10),
    .MAX_WORDS (1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      if (prev_we) chk("we_back_to_back", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {22'd0, mem_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {22'd0, mem_waddr}, {22'd0, e.addr});
        chk("write_data", mem_wdata, e.data);
      end
    end
    prev_we = (mem_we === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit noise);
    bit acc = 1'b0;
    bit rdy;
    int guard = 0;
    while (!acc) begin
      rx_data  = b;
      rx_valid = ($urandom_range(99) >= gap_pct);
      start    = noise ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      rdy = rx_ready;
      @(posedge clk);
      #1;
      acc = rx_valid && rdy;
      guard++;
      if (!acc && guard > 60) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Runs one session for header n and the words in img.
  task automatic load(input logic [31:0] n, input int gap_pct, input bit noise);
    bit ok = (n != 0) && (n <= 1024);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_after_start", {31'd0, rx_ready}, 32'd1);
    chk("cpu_rst_after_start", {31'd0, cpu_rst_n}, 32'd0);
    chk("word_count_cleared", {21'd0, word_count}, 32'd0);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) exp_q.push_back('{addr: 10'(i), data: img[i]});
    end
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], gap_pct, noise);
    if (!ok) begin
      chk("err_bad_len", {31'd0, err}, 32'd1);
      chk("ready_after_err", {31'd0, rx_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("err_held", {31'd0, err}, 32'd1);
      chk("cpu_rst_after_err", {31'd0, cpu_rst_n}, 32'd0);
      chk("word_count_after_err", {21'd0, word_count}, 32'd0);
      return;
    end
    chk("word_count_latched", {21'd0, word_count}, n);
    for (int i = 0; i < int'(n); i++) begin
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], gap_pct, noise);
    end
    chk("done_with_last_write", {31'd0, done}, 32'd1);
    chk("last_we_high", {31'd0, mem_we}, 32'd1);
    chk("cpu_rst_still_low", {31'd0, cpu_rst_n}, 32'd0);
    @(posedge clk);
    #1;
    chk("cpu_rst_released", {31'd0, cpu_rst_n}, 32'd1);
    chk("ready_after_done", {31'd0, rx_ready}, 32'd0);
    chk("writes_outstanding", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    #3;
    chk("reset_outputs", {rx_ready, mem_we, cpu_rst_n, busy, done, err, word_count},
        32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    #19 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_ready", {31'd0, rx_ready}, 32'd0);
    chk("idle_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Two-word image, continuous then gapped.
    img = '{32'h0010_0513, 32'h0000_006F};
    load(32'd2, 0, 1'b0);
    load(32'd2, 50, 1'b0);

    // Bad lengths, then recovery with a one-word image.
    load(32'd0, 0, 1'b0);
    load(32'd1025, 30, 1'b0);
    img = '{$urandom()};
    load(32'd1, 0, 1'b0);

    for (int s = 0; s < 4; s++) begin
      int n = $urandom_range(1, 8);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
      load(32'(n), $urandom_range(60), 1'b1);
    end

    // Full memory with start pulses sprinkled through the stream.
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back(32'(i) ^ 32'hA5A5_A5A5);
    load(32'd1024, 0, 1'b1);
    chk("full_last_addr", {22'd0, mem_waddr}, 32'd1023);
    chk("full_last_data", mem_wdata, 32'hA5A5_A65A);
    chk("full_done", {31'd0, done}, 32'd1);

    // Reset after 3 of 5 words.
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back($urandom());
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back('{addr: 10'(i), data: img[i]});
    for (int b = 0; b < 4; b++) send_byte(8'(5 >> (8 * b)), 20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], 20, 1'b0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {rx_ready, mem_we, cpu_rst_n, busy, done, err, word_count},
        32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("midreset_idle", {29'd0, busy, rx_ready, cpu_rst_n}, 32'd0);
    chk("midreset_writes", exp_q.size(), 32'd0);

    img.delete();
    for (int i = 0; i < 6; i++) img.push_back($urandom());
    load(32'd6, 25, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
